// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 requester with a wait-state timeout
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PClk,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [CW-1:0]         wait_inc;
    logic                  timeout_hit;

    // saturating wait count and the timeout decision it feeds
    always_comb begin
        wait_inc    = (&wait_q) ? wait_q : wait_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (wait_inc == TO_LIMIT);
    end

    // next-state and next-output logic; all outputs come straight from flops
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_d      = wait_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_ready_q && cmd_valid) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr & ~ADDR_WIDTH'(3);
                    pwdata_d    = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else begin
                    wait_d = wait_inc;
                    if (timeout_hit) begin
                        state_d     = RESP;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
        endcase
    end

    // state and output registers, cleared asynchronously so the bus drops at once
    always_ff @(posedge PClk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a planned-behaviour APB slave model
module tb_apb_master_bridge;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          vcyc;
        int          hold;
    } exp_t;

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        bit          pwrite;
        int          w;
        logic [31:0] rd;
        bit          e;
        int          acc;
    } plan_t;

    logic        clk = 1'b0;
    logic        PRESETn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    logic        z_cmd_valid = 1'b0, z_rsp_ready = 1'b1;
    logic [31:0] z_cmd_addr = 32'h100, z_cmd_wdata = '0;
    logic        z_cmd_ready, z_rsp_valid, z_rsp_err, z_psel, z_penable, z_pwrite;
    logic [31:0] z_rsp_rdata, z_paddr, z_pwdata;
    logic [31:0] z_prdata = '0;
    logic        z_pready = 1'b0;

    int    cyc = 0;
    int    n_total = 0, n_pass = 0;
    exp_t  exp_q[$];
    plan_t slv_q[$];
    bit    rnd_rdy = 1'b0;
    int    hold = 0;
    bit    prev_rv = 1'b0;
    plan_t cur;
    bit    in_xfer = 1'b0;
    int    acc_n = 0;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .PClk(clk), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(psel), .PADDR(paddr), .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) dut0 (
        .PClk(clk), .PRESETn(PRESETn),
        .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_write(1'b0),
        .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .PSEL(z_psel), .PADDR(z_paddr), .PENABLE(z_penable), .PWRITE(z_pwrite), .PWDATA(z_pwdata),
        .PRDATA(z_prdata), .PREADY(z_pready), .PSLVERR(1'b0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Issue one command; the plan tells the slave model how to answer and the
    // scoreboard what response, when, and how long to back-pressure it.
    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input int w,
                          input logic [31:0] rd, input bit e, input int hld, output int hs);
        exp_t  x;
        plan_t p;
        bit    tmo;
        int    n;
        tmo = (w >= TO);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        hs = cyc;
        p.paddr  = {a[31:2], 2'b00};
        p.pwdata = wr ? d : 32'h0;
        p.pwrite = wr;
        p.w      = w;
        p.rd     = rd;
        p.e      = e;
        p.acc    = tmo ? TO : w + 1;
        x.rdata  = (tmo || wr) ? 32'h0 : rd;
        x.err    = tmo ? 1'b1 : e;
        x.vcyc   = hs + 2 + p.acc;
        x.hold   = hld;
        if (cmd_ready) begin
            slv_q.push_back(p);
            exp_q.push_back(x);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || slv_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size() + slv_q.size(), 0);
    endtask

    // APB slave model: checks the captured command, then answers per plan
    always @(negedge clk) begin
        bit rdy;
        if (!PRESETn) in_xfer = 1'b0;
        else if (psel && !penable) begin
            chk("setup_expected", slv_q.size() != 0, 1);
            if (slv_q.size() != 0) begin
                cur = slv_q.pop_front();
                in_xfer = 1'b1;
                acc_n = 0;
                chk("setup_paddr", paddr, cur.paddr);
                chk("setup_pwrite", pwrite, cur.pwrite);
                chk("setup_pwdata", pwdata, cur.pwdata);
            end
        end else if (psel && penable && in_xfer) begin
            acc_n++;
            chk("access_paddr", paddr, cur.paddr);
            chk("access_pwrite", pwrite, cur.pwrite);
            chk("access_pwdata", pwdata, cur.pwdata);
        end else if (!psel && in_xfer) begin
            chk("access_len", acc_n, cur.acc);
            in_xfer = 1'b0;
        end
        rdy     = in_xfer && psel && penable && (acc_n > cur.w);
        pready  = rdy ? 1'b1 : ((psel && penable) ? 1'b0 : 1'($urandom_range(0, 1)));
        prdata  = rdy ? cur.rd : $urandom;
        pslverr = rdy ? cur.e : 1'($urandom_range(0, 1));
    end

    // response monitor and scoreboard; also owns rsp_ready
    always @(negedge clk) begin
        if (!PRESETn) begin
            hold = 0;
            prev_rv = 1'b0;
        end else begin
            if (rsp_valid && !prev_rv) begin
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("rsp_latency", cyc, exp_q[0].vcyc);
                    hold = exp_q[0].hold;
                end
            end
            rsp_ready = (hold > 0) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            if (hold > 0) hold--;
            if (rsp_valid && exp_q.size() != 0) begin
                chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                chk("rsp_err", rsp_err, exp_q[0].err);
                if (rsp_ready) void'(exp_q.pop_front());
            end
            chk("no_apb_in_resp", rsp_valid && psel, 0);
            chk("ready_only_idle", cmd_ready && (psel || rsp_valid), 0);
            prev_rv = rsp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  hs1, hs2, n;
        bit  wr, ok;
        int  w;
        #2 PRESETn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready}, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        #1 PRESETn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // write zero waits, then back-to-back write: 4-cycle throughput
        do_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, $urandom, 1'b0, 0, hs1);
        do_cmd(1'b1, 32'h0000_0014, 32'h0BAD_F00D, 0, $urandom, 1'b0, 0, hs2);
        chk("throughput_gap", hs2 - hs1, 4);
        // read with three waits, unaligned address
        do_cmd(1'b0, 32'h0000_0027, $urandom, 3, 32'h1234_5678, 1'b0, 0, hs1);
        // slave error read
        do_cmd(1'b0, 32'h0000_0040, $urandom, 1, 32'hFFFF_FFFF, 1'b1, 0, hs1);
        // stalled slave forces a timeout
        do_cmd(1'b0, 32'h0000_0080, $urandom, 40, 32'hCAFE_0001, 1'b0, 0, hs1);
        // backpressure on first of two queued writes
        do_cmd(1'b1, 32'h0000_0100, 32'h1111_2222, 0, $urandom, 1'b0, 5, hs1);
        do_cmd(1'b1, 32'h0000_0104, 32'h3333_4444, 0, $urandom, 1'b0, 0, hs2);
        chk("backpressure_gap", hs2 - hs1, 9);
        drain();

        // TIMEOUT=0 instance waits indefinitely
        z_cmd_valid = 1'b1;
        n = 0;
        while (!z_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        z_cmd_valid = 1'b0;
        @(negedge clk);
        ok = 1'b1;
        repeat (100) begin
            if (!(z_psel && z_penable && !z_rsp_valid)) ok = 1'b0;
            @(negedge clk);
        end
        chk("to0_waits", ok, 1);
        z_prdata = 32'hA5A5_0F0F;
        z_pready = 1'b1;
        @(negedge clk);
        z_pready = 1'b0;
        chk("to0_rsp_valid", z_rsp_valid, 1);
        chk("to0_rsp_rdata", z_rsp_rdata, 32'hA5A5_0F0F);
        chk("to0_rsp_err", z_rsp_err, 0);

        // randomized traffic
        rnd_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            wr = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
            do_cmd(wr, $urandom, $urandom, w, $urandom, $urandom_range(0, 3) == 0,
                   int'($urandom_range(0, 3)), hs1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rnd_rdy = 1'b0;

        // reset in the middle of a waited read
        do_cmd(1'b0, 32'h0000_0200, $urandom, 10, 32'h7777_8888, 1'b0, 0, hs1);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready}, 0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_pwdata", pwdata, 0);
        chk("midrst_rdata", rsp_rdata, 0);
        exp_q.delete();
        slv_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1 PRESETn = 1'b1;
        @(negedge clk);
        do_cmd(1'b0, 32'h0000_0304, $urandom, 2, 32'h5A5A_A5A5, 1'b0, 0, hs1);
        do_cmd(1'b1, 32'h0000_0308, 32'h0102_0304, 0, $urandom, 1'b0, 0, hs2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that turns single-beat commands from an internal valid/ready command port into APB3 transfers (SETUP then ACCESS phases) and returns each result on a valid/ready response port. It is the initiating end of the APB bus that our peripheral slaves respond on, and serves as the bus driver for CPU-less subsystems and for slave bring-up. It adds a wait-state timeout so a stalled slave cannot hang the requester.

## Interface
- ADDR_WIDTH, 32, APB address width in bits.
- DATA_WIDTH, 32, APB data width in bits.
- TIMEOUT, 16, maximum ACCESS-phase cycles before forced termination; 0 disables the timeout.

- PClk  input  1  clock; all logic on rising edge.
- PRESETn  input  1  reset, asynchronous assert, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge accepts a command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and on timeout.
- rsp_err  output  1  PSLVERR seen or timeout.
- PSEL  output  1  APB select.
- PADDR  output  ADDR_WIDTH  APB address.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_WIDTH  APB write data.
- PRDATA  input  DATA_WIDTH  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. When cmd_valid=1, capture cmd_write/cmd_addr/cmd_wdata and go to SETUP.
- Captured PADDR has bits [1:0] forced to 0.
- Captured PWDATA is 0 for reads.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Clear the wait counter. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - If PREADY=1: capture rsp_rdata (PRDATA for reads, 0 for writes) and rsp_err=PSLVERR, then go to RESP.
  - Else: increment the wait counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, set rsp_rdata=0 and rsp_err=1, then go to RESP.
- Timeout counter width: clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. rsp_rdata and rsp_err are held until rsp_ready=1, then go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They keep their last values in RESP and IDLE and change only on command capture.
- PSLVERR and PRDATA are sampled only in ACCESS when PREADY=1.
- Only one transfer is outstanding at a time. cmd_ready=0 outside IDLE.

## Timing
- Reset values (while PRESETn=0, asynchronous):
  - state=IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - cmd_ready=0 during reset, 1 from the first edge after release.
- Latency, command handshake at edge N:
  - SETUP occupies cycle N+1.
  - ACCESS starts at cycle N+2.
  - With zero wait states, rsp_valid=1 at cycle N+3.
  - Each PREADY=0 cycle in ACCESS adds 1 cycle.
- Throughput: a transfer occupies 4 cycles minimum when rsp_ready is held at 1. The next cmd_ready is at N+4.
- Timeout: with PREADY stuck at 0, ACCESS lasts TIMEOUT cycles and rsp_valid rises on the following cycle.
- Response backpressure: rsp_valid stays high with stable data while rsp_ready=0. No APB activity occurs meanwhile.
- Reset mid-transfer: PSEL and PENABLE drop immediately. Any pending response is discarded. No response is produced for the aborted command.

## Test plan
- Write, zero waits: cmd write addr 0x0000_0010, data 0xDEAD_BEEF, PREADY=1.
  - APB: SETUP cycle with PSEL=1 PENABLE=0, then ACCESS cycle with PENABLE=1, PWRITE=1, PADDR=0x10, PWDATA=0xDEADBEEF.
  - Response: rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read, 3 waits: cmd read addr 0x0000_0027; slave holds PREADY=0 for 3 cycles, then PREADY=1 with PRDATA=0x1234_5678.
  - PADDR=0x24 stable throughout.
  - Response: rsp_rdata=0x12345678, rsp_err=0, rsp_valid at N+6.
- Slave error: read returning PSLVERR=1, PRDATA=0xFFFF_FFFF.
  - Response: rsp_err=1, rsp_rdata=0xFFFFFFFF.
- Timeout, TIMEOUT=16: PREADY stuck at 0.
  - ACCESS lasts 16 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0.
  - With TIMEOUT=0 the bridge waits indefinitely (verify for 100 cycles).
- Backpressure and back-to-back: two queued writes with rsp_ready=0 for 5 cycles on the first response.
  - Response stays stable.
  - Second SETUP occurs only after the first rsp handshake, and cmd_ready=0 throughout.
- Reset mid-ACCESS: assert PRESETn=0 during a waited read.
  - PSEL and PENABLE drop asynchronously and all outputs take their reset values.
  - After release the next command completes normally.
